// File: rtl/lut_eval_pkg.sv
// Shared types and limits for the LUT evaluation pipeline.
package lut_eval_pkg;

    // Largest supported number of logic inputs (64-entry table).
    localparam int unsigned N_MAX = 6;

    // Controller states: evaluate inputs, or shift in a new truth table.
    typedef enum logic {
        StRun  = 1'b0,
        StLoad = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_delay.sv
// Valid+data delay line of DEPTH register stages; DEPTH=0 is a plain wire.
// A stage's data register only loads alongside a valid, so data_o keeps the
// last delivered value while valid_o is low.
module pipe_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_bypass
        assign valid_o = valid_i;
        assign data_o  = data_i;
    end else begin : g_pipe
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            logic             v_in;
            logic [WIDTH-1:0] d_in;
            logic             v_q;
            logic [WIDTH-1:0] d_q;

            if (g == 0) begin : g_head
                assign v_in = valid_i;
                assign d_in = data_i;
            end else begin : g_link
                assign v_in = g_stage[g-1].v_q;
                assign d_in = g_stage[g-1].d_q;
            end

            // One shift stage; data moves only with a valid token.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    v_q <= 1'b0;
                    d_q <= '0;
                end else begin
                    v_q <= v_in;
                    if (v_in) begin
                        d_q <= d_in;
                    end
                end
            end
        end

        assign valid_o = g_stage[DEPTH-1].v_q;
        assign data_o  = g_stage[DEPTH-1].d_q;
    end

endmodule

// File: rtl/lut_eval_pipe.sv
// Pipelined N-input lookup-table evaluator with a serially reloadable table.
// Stage 1 does the lookup; pipe_delay adds the remaining LAT-1 stages.
module lut_eval_pipe
    import lut_eval_pkg::*;
#(
    parameter int unsigned     N    = 3,
    parameter int unsigned     LAT  = 2,
    parameter logic [2**N-1:0] INIT = 8'h31
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_x,
    output logic            out_valid,
    output logic            out_y,
    output logic [2**N-1:0] table_o
);

    localparam int unsigned TblW    = 2**N;
    localparam logic [N:0]  LastIdx = (N+1)'(TblW - 1);

    if (N < 1 || N > N_MAX || LAT < 1 || LAT > 4) begin : g_bad_param
        $error("lut_eval_pipe: N or LAT out of supported range");
    end

    state_e            state_q, state_d;
    logic [TblW-1:0]   table_q, table_d;
    logic [TblW-1:0]   shadow_q, shadow_d;
    logic [N:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              s1_valid_q;
    logic              s1_y_q;
    logic              accept;

    assign in_ready = (state_q == StRun);
    assign accept   = in_valid & in_ready;
    assign cfg_done = done_q;
    assign table_o  = table_q;

    // Load controller: restart on cfg_start, shift bits in, swap table on the last bit.
    always_comb begin
        state_d  = state_q;
        table_d  = table_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (cfg_start) begin
                    state_d  = StLoad;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            StLoad: begin
                // cfg_start wins over a coincident cfg_valid; that bit is dropped.
                if (cfg_start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (cfg_valid) begin
                    shadow_d[cnt_q[N-1:0]] = cfg_bit;
                    cnt_d                  = cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        table_d = shadow_d;
                        state_d = StRun;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Controller and table registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            table_q  <= INIT;
            shadow_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            table_q  <= table_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    // Stage 1: look up the accepted code in the table active at acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_y_q     <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_y_q <= table_q[in_x];
            end
        end
    end

    pipe_delay #(
        .WIDTH (1),
        .DEPTH (LAT - 1)
    ) u_delay (
        .clk_i   (clk),
        .rst_i   (reset),
        .valid_i (s1_valid_q),
        .data_i  (s1_y_q),
        .valid_o (out_valid),
        .data_o  (out_y)
    );

endmodule

// File: doc/lut_eval_pipe.md
LUT_EVAL_PIPE -- requirements
Module: lut_eval_pipe

Interface
REQ-001 SHALL have parameter N, default 3, meaning number of logic inputs; legal range 1..6.
REQ-002 SHALL have parameter LAT, default 2, meaning cycles from accepted input to output; legal range 1..4.
REQ-003 SHALL have parameter INIT, width 2**N, default 8'h31, meaning the reset truth table (bit i = output for input code i).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port cfg_start, input, 1, pulse that begins a serial truth-table load.
REQ-007 SHALL have port cfg_valid, input, 1, qualifier for cfg_bit during a load.
REQ-008 SHALL have port cfg_bit, input, 1, next truth-table bit, index 0 first.
REQ-009 SHALL have port cfg_done, output, 1, one-cycle pulse when a new table becomes active.
REQ-010 SHALL have port in_valid, input, 1, qualifier for in_x.
REQ-011 SHALL have port in_ready, output, 1, high when an input is accepted this cycle.
REQ-012 SHALL have port in_x, input, N, input code; in_x[N-1] is the MSB of the table index.
REQ-013 SHALL have port out_valid, output, 1, qualifier for out_y.
REQ-014 SHALL have port out_y, output, 1, evaluated function value.
REQ-015 SHALL have port table_o, output, 2**N, currently active truth table.

Function
REQ-016 SHALL implement a two-state FSM: RUN (evaluate) and LOAD (shift in table).
REQ-017 SHALL, in RUN, drive in_ready=1; in LOAD, drive in_ready=0 and ignore in_valid.
REQ-018 SHALL accept an input when in_valid & in_ready, computing active_table[in_x] into pipeline stage 1.
REQ-019 SHALL present out_valid=1 with out_y exactly LAT cycles after acceptance; no backpressure, one result per accepted input, order preserved.
REQ-020 SHALL keep out_valid=0 in every cycle not LAT cycles after an acceptance; out_y holds its last value when out_valid=0.
REQ-021 SHALL, on cfg_start in RUN, enter LOAD next cycle with bit counter 0 and the shadow table cleared.
REQ-022 SHALL, in LOAD, on each cfg_valid cycle write cfg_bit to shadow[counter] and increment the counter; cycles without cfg_valid hold.
REQ-023 SHALL, on the cycle the (2**N)-th bit is written, copy shadow to the active table at that edge, return to RUN, and pulse cfg_done in the following cycle.
REQ-024 SHALL treat cfg_start during LOAD as a restart: counter and shadow reset to 0, active table unchanged.
REQ-025 SHALL give cfg_start priority over cfg_valid when both are asserted in LOAD (the bit is discarded).
REQ-026 SHALL let results already in the pipeline complete using the table at their acceptance time; entering LOAD does not flush them.
REQ-027 SHALL ignore cfg_valid and cfg_bit in RUN.
REQ-028 SHALL, with cfg_start and in_valid both high in RUN, accept the input (old table) and enter LOAD.

Reset
REQ-029 SHALL, while reset is high at a clock edge, set state=RUN, active table=INIT, shadow=0, counter=0, cfg_done=0, out_valid=0, out_y=0, all pipeline stages invalid.
REQ-030 SHALL abandon any partial load on reset without altering the INIT table result.
REQ-031 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-032 SHALL place the state enum (RUN, LOAD) and constant N_MAX=6 in package lut_eval_pkg.
REQ-033 SHALL implement the output delay in sub-module pipe_delay (parameters WIDTH, DEPTH; valid+data shift register with synchronous reset), instantiated with DEPTH=LAT-1 (pass-through when 0).
REQ-034 SHALL size the bit counter as N+1 bits to reach 2**N without wrap.

Verification
REQ-035 SHALL cover: reset, N=3, LAT=2, drive in_x=0..7 back-to-back -> out_y sequence 1,0,0,0,1,1,0,0 starting two cycles after first acceptance, out_valid high 8 cycles.
REQ-036 SHALL cover: cfg_start then 8 cfg_valid bits of 8'hA5 (LSB first) with two idle gaps -> cfg_done one cycle after 8th bit, table_o=8'hA5, in_x=1 -> out_y=0, in_x=2 -> out_y=1.
REQ-037 SHALL cover: cfg_start after 5 bits, then full load of 8'hFF -> table_o=8'hFF, only one cfg_done.
REQ-038 SHALL cover: in_valid held through LOAD -> in_ready=0, no out_valid for LOAD cycles beyond in-flight results; in-flight result uses old table.
REQ-039 SHALL cover: reset asserted after 4 load bits -> table_o=8'h31, state RUN, out_valid=0.
REQ-040 SHALL cover: N=1, LAT=1 and N=6, LAT=4 builds -> latency exactly LAT, 64-bit load completes with cfg_done.
